uart_rx_oversampled: RTL and testbench

- UART receiver; the consuming end of the baud tick produced by the baud-rate generator.
- Samples the serial line on a 16x-oversampled enable tick and recovers 8N1 frames (optional parity).
- Presents each received byte with a one-cycle valid pulse.
- Sits between the pad-side rx pin and the parallel data consumer, clocked by the system 50 MHz clock.

---
 rtl/uart_rx_oversampled.sv | 160 ++++++++++++++++
 tb/tb_uart_rx_oversampled.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled: 16x-oversampled 8N1 UART receiver with optional even parity (enable with UART_RX_PARITY_EN).
module uart_rx_oversampled #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 baud_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_error,
    output logic                 parity_error,
    output logic                 busy
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] HALF  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] LAST  = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BLAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

    state_t               state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                 rxs;
    logic [CW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
    logic                 valid_q, valid_d, ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic                 perr_q, perr_d, pbad_q, pbad_d;
`endif

    // rx crosses into the clock domain through a shift chain preset to idle-high
    always_ff @(posedge clock) begin
        if (reset) sync_q <= '1;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end

    assign rxs = sync_q[SYNC_STAGES-1];

    // state and datapath registers; a reset mid-frame discards everything
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q  <= 1'b0;
            pbad_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            perr_q  <= perr_d;
            pbad_q  <= pbad_d;
`endif
        end
    end

    // frame FSM advancing on baud ticks; result pulses default low every clock
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d  = 1'b0;
        pbad_d  = pbad_q;
`endif
        if (baud_tick) begin
            case (state_q)
                IDLE: begin
                    if (!rxs) begin
                        state_d = START;
                        tick_d  = '0;
                    end
                end
                START: begin
                    if (tick_q == HALF) begin
                        state_d = rxs ? IDLE : DATA;
                        tick_d  = '0;
                        bit_d   = '0;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_q == LAST) begin
                        tick_d  = '0;
                        shift_d = DATA_BITS'({rxs, shift_q} >> 1);
                        if (bit_q == BLAST)
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        else
                            bit_d = bit_q + 1'b1;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick_q == LAST) begin
                        tick_d  = '0;
                        pbad_d  = (^shift_q) ^ rxs;
                        state_d = STOP;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (tick_q == LAST) begin
                        tick_d  = '0;
                        data_d  = shift_q;
                        valid_d = rxs;
                        ferr_d  = !rxs;
`ifdef UART_RX_PARITY_EN
                        perr_d  = pbad_q;
`endif
                        state_d = rxs ? IDLE : WAIT_HIGH;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                WAIT_HIGH: state_d = rxs ? IDLE : WAIT_HIGH;
                default:   state_d = IDLE;
            endcase
        end
    end

    assign data_out    = data_q;
    assign data_valid  = valid_q;
    assign frame_error = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_error = perr_q;
`else
    assign parity_error = 1'b0;
`endif
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb_uart_rx_oversampled: directed frames against uart_rx_oversampled with baud_tick held high.
module tb_uart_rx_oversampled;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       baud_tick = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] data_out;
    logic       data_valid, frame_error, parity_error, busy;

    int vectors = 0;
    int miscompares = 0;
    int valid_cnt = 0, fe_cnt = 0, pe_cnt = 0, pe_with_valid = 0;
    logic [7:0] last_data = 8'h00, prev_data = 8'h00;

    uart_rx_oversampled dut (
        .clock(clock), .reset(reset), .baud_tick(baud_tick), .rx(rx),
        .data_out(data_out), .data_valid(data_valid), .frame_error(frame_error),
        .parity_error(parity_error), .busy(busy)
    );

    always #5 clock = ~clock;

    // count every cycle a pulse is high so a stretched pulse shows up as an extra count
    always @(negedge clock) begin
        if (data_valid) begin
            valid_cnt <= valid_cnt + 1;
            prev_data <= last_data;
            last_data <= data_out;
            if (parity_error) pe_with_valid <= pe_with_valid + 1;
        end
        if (frame_error)  fe_cnt <= fe_cnt + 1;
        if (parity_error) pe_cnt <= pe_cnt + 1;
    end

    task automatic tick_n(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
        rx = 1'b0;
        tick_n(16);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick_n(16);
        end
`ifdef UART_RX_PARITY_EN
        rx = par;
        tick_n(16);
`else
        if (par === 1'bx) rx = 1'b1;
`endif
        rx = stop;
        tick_n(16);
    endtask

    initial begin
        tick_n(3);
        check("rst_data", {24'h0, data_out}, 32'h00);
        check("rst_valid", {31'h0, data_valid}, 32'h0);
        check("rst_ferr", {31'h0, frame_error}, 32'h0);
        check("rst_perr", {31'h0, parity_error}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        reset = 1'b0;
        tick_n(5);

        send_frame(8'hA5, 1'b1, ^8'hA5);
        tick_n(20);
        check("a5_vcnt", valid_cnt, 1);
        check("a5_last", {24'h0, last_data}, 32'hA5);
        check("a5_data", {24'h0, data_out}, 32'hA5);
        check("a5_fcnt", fe_cnt, 0);
        check("a5_busy", {31'h0, busy}, 32'h0);

        rx = 1'b0;
        tick_n(4);
        rx = 1'b1;
        tick_n(40);
        check("glitch_vcnt", valid_cnt, 1);
        check("glitch_busy", {31'h0, busy}, 32'h0);
        send_frame(8'h3C, 1'b1, ^8'h3C);
        tick_n(20);
        check("3c_vcnt", valid_cnt, 2);
        check("3c_last", {24'h0, last_data}, 32'h3C);

        send_frame(8'h3C, 1'b0, ^8'h3C);
        tick_n(40);
        check("brk_fcnt", fe_cnt, 1);
        check("brk_vcnt", valid_cnt, 2);
        check("brk_data", {24'h0, data_out}, 32'h3C);
        check("brk_busy", {31'h0, busy}, 32'h1);
        rx = 1'b1;
        tick_n(10);
        check("brk_idle", {31'h0, busy}, 32'h0);
        check("brk_fcnt2", fe_cnt, 1);
        tick_n(10);

        send_frame(8'h00, 1'b1, ^8'h00);
        send_frame(8'hFF, 1'b1, ^8'hFF);
        tick_n(20);
        check("b2b_vcnt", valid_cnt, 4);
        check("b2b_first", {24'h0, prev_data}, 32'h00);
        check("b2b_second", {24'h0, last_data}, 32'hFF);

        rx = 1'b0;
        tick_n(16);
        for (int i = 0; i < 4; i++) begin
            rx = (i == 0);
            tick_n(16);
        end
        rx = 1'b0;
        tick_n(8);
        reset = 1'b1;
        tick_n(1);
        check("mrst_data", {24'h0, data_out}, 32'h00);
        check("mrst_valid", {31'h0, data_valid}, 32'h0);
        check("mrst_ferr", {31'h0, frame_error}, 32'h0);
        check("mrst_busy", {31'h0, busy}, 32'h0);
        reset = 1'b0;
        rx = 1'b1;
        tick_n(20);
        check("mrst_vcnt", valid_cnt, 4);
        send_frame(8'h81, 1'b1, ^8'h81);
        tick_n(20);
        check("81_vcnt", valid_cnt, 5);
        check("81_data", {24'h0, data_out}, 32'h81);
        check("pe_none", pe_cnt, 0);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1);
        tick_n(20);
        check("par_ok_vcnt", valid_cnt, 6);
        check("par_ok_pcnt", pe_cnt, 0);
        send_frame(8'h07, 1'b1, 1'b0);
        tick_n(20);
        check("par_bad_vcnt", valid_cnt, 7);
        check("par_bad_pcnt", pe_cnt, 1);
        check("par_bad_with_valid", pe_with_valid, 1);
        check("par_bad_data", {24'h0, data_out}, 32'h07);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
